// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the execute/memory boundary logic.
//   ALU_* : 4-bit ALU control codes carried alongside each result.
//   exc_state_t : overflow exception FSM state (IDLE / PEND).
//   is_addsub() : true for the two codes that update the status flags.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b1111;
  localparam logic [3:0] ALU_SUB = 4'b1110;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0001;
  localparam logic [3:0] ALU_DIV = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1011;
  localparam logic [3:0] ALU_ROL = 4'b1000;
  localparam logic [3:0] ALU_ROR = 4'b1001;

  typedef enum logic {
    EXC_IDLE = 1'b0,
    EXC_PEND = 1'b1
  } exc_state_t;

  function automatic logic is_addsub(input logic [3:0] crtl);
    return (crtl == ALU_ADD) || (crtl == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_result_latch_skid_buf2.sv
// skid_buf2: generic two-entry valid/ready buffer with synchronous flush.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : drop both entries at the next edge
//   in_valid / in_ready : upstream handshake; in_ready depends on state only
//   in_data             : W-bit payload
//   out_valid/out_ready : downstream handshake for the head entry
//   out_data            : head payload
// The head entry drives the output. A new word lands in head when head is
// empty or leaving; otherwise it parks in skid. Skid always refills head
// before new input is taken, so ordering is preserved.
module skid_buf2 #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         head_valid_reg;
  logic         skid_valid_reg;
  logic [W-1:0] head_data_reg;
  logic [W-1:0] skid_data_reg;
  logic         accept;
  logic         head_free;

  assign in_ready  = !skid_valid_reg;
  assign accept    = in_valid && !skid_valid_reg;
  assign head_free = !head_valid_reg || out_ready;
  assign out_valid = head_valid_reg;
  assign out_data  = head_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      head_data_reg  <= '0;
      skid_data_reg  <= '0;
    end else if (flush) begin
      head_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (head_free) begin
      if (skid_valid_reg) begin
        // in_ready was low, so nothing new can arrive this cycle
        head_data_reg  <= skid_data_reg;
        head_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else begin
        head_valid_reg <= accept;
        if (accept) head_data_reg <= in_data;
      end
    end else if (accept) begin
      skid_data_reg  <= in_data;
      skid_valid_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_latch.sv
// alu_result_latch: execute-to-memory boundary register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ex_valid/ex_ready : result handshake from execute
//   alu_r, alu_o      : ALU result and overflow
//   ex_crtl           : ALU control code that produced alu_r
//   ex_rd, ex_wen     : destination register and writeback enable
//   flush             : discard buffered and presented results
//   mem_valid/ready   : head handshake to memory stage
//   mem_r/rd/wen      : head payload
//   flag_n/z/o        : status flags, updated by accepted add/sub only
//   exc_req, exc_ack  : overflow exception request / acknowledge
// Build option: define ALU_OVF_EXC_EN to enable the precise overflow
// exception (writeback suppressed, execute stalled until exc_ack).
import alu_pkg::*;

module alu_result_latch #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] alu_r,
  input  logic          alu_o,
  input  logic [3:0]    ex_crtl,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_wen,
  input  logic          flush,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [DW-1:0] mem_r,
  output logic [RW-1:0] mem_rd,
  output logic          mem_wen,
  output logic          flag_n,
  output logic          flag_z,
  output logic          flag_o,
  output logic          exc_req,
  input  logic          exc_ack
);

  localparam int PW = DW + RW + 1;

  logic          buf_ready;
  logic          accept;
  logic          addsub;
  logic          wen_eff;
  logic [PW-1:0] mem_payload;

  assign addsub = is_addsub(ex_crtl);
  // A result presented during flush is dropped outright.
  assign accept = ex_valid && ex_ready && !flush;

`ifdef ALU_OVF_EXC_EN
  exc_state_t exc_state_reg;
  logic       ovf_take;

  assign ex_ready = buf_ready && (exc_state_reg == EXC_IDLE);
  assign ovf_take = accept && addsub && alu_o;
  assign wen_eff  = ex_wen && !ovf_take;
  assign exc_req  = (exc_state_reg == EXC_PEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_state_reg <= EXC_IDLE;
    end else begin
      case (exc_state_reg)
        EXC_IDLE: if (ovf_take) exc_state_reg <= EXC_PEND;
        EXC_PEND: if (exc_ack)  exc_state_reg <= EXC_IDLE;
        default:                exc_state_reg <= EXC_IDLE;
      endcase
    end
  end
`else
  logic unused_exc_ack;

  assign unused_exc_ack = exc_ack;
  assign ex_ready       = buf_ready;
  assign wen_eff        = ex_wen;
  assign exc_req        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_o <= 1'b0;
    end else if (accept && addsub) begin
      // N comes from the result for both add and sub
      flag_n <= alu_r[DW-1];
      flag_z <= (alu_r == '0);
      flag_o <= alu_o;
    end
  end

  skid_buf2 #(
    .W(PW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (accept),
    .in_ready  (buf_ready),
    .in_data   ({alu_r, ex_rd, wen_eff}),
    .out_valid (mem_valid),
    .out_ready (mem_ready),
    .out_data  (mem_payload)
  );

  assign {mem_r, mem_rd, mem_wen} = mem_payload;

endmodule

// File: tb/tb_alu_result_latch.sv
// Self-checking bench for alu_result_latch: directed table, hand-written
// exception/reset sequences and a randomized run against a queue model.
module tb_alu_result_latch;
  import alu_pkg::*;

`ifdef ALU_OVF_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [15:0] alu_r;
  logic        alu_o;
  logic [3:0]  ex_crtl;
  logic [3:0]  ex_rd;
  logic        ex_wen, flush;
  logic        mem_valid, mem_ready;
  logic [15:0] mem_r;
  logic [3:0]  mem_rd;
  logic        mem_wen, flag_n, flag_z, flag_o, exc_req, exc_ack;

  alu_result_latch dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_r(alu_r), .alu_o(alu_o), .ex_crtl(ex_crtl), .ex_rd(ex_rd),
    .ex_wen(ex_wen), .flush(flush), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_r(mem_r), .mem_rd(mem_rd),
    .mem_wen(mem_wen), .flag_n(flag_n), .flag_z(flag_z), .flag_o(flag_o),
    .exc_req(exc_req), .exc_ack(exc_ack)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: an ordered list of results waiting for the memory stage
  typedef struct {
    logic [15:0] r;
    logic [3:0]  rd;
    logic        wen;
  } ent_t;
  ent_t q[$];
  logic m_n, m_z, m_o, m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_n = 1'b0; m_z = 1'b0; m_o = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_check();
    chk("m_valid", mem_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("m_r", mem_r, q[0].r);
      chk("m_rd", mem_rd, q[0].rd);
      chk("m_wen", mem_wen, q[0].wen);
    end
    chk("m_ready", ex_ready, (q.size() < 2) && !m_pend);
    chk("m_flags", {flag_n, flag_z, flag_o}, {m_n, m_z, m_o});
    chk("m_exc", exc_req, m_pend);
  endtask

  // Drive one cycle of inputs, check the model against current outputs,
  // advance the model, then move past the clock edge.
  task automatic step(input logic v, input logic [3:0] c, input logic [15:0] r,
                      input logic o, input logic [3:0] rd, input logic wen,
                      input logic mr, input logic fl, input logic ack);
    logic acc, as, ovf;
    ex_valid = v; ex_crtl = c; alu_r = r; alu_o = o; ex_rd = rd;
    ex_wen = wen; mem_ready = mr; flush = fl; exc_ack = ack;
    #1;
    model_check();
    acc = v && (q.size() < 2) && !m_pend && !fl;
    as  = (c == ALU_ADD) || (c == ALU_SUB);
    ovf = EXC_EN && acc && as && o;
    $display("[TB] t=%0t v=%b crtl=%h r=%h o=%b mr=%b fl=%b ack=%b acc=%b", $time, v, c, r, o, mr, fl, ack, acc);
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && mr) void'(q.pop_front());
      if (acc) q.push_back('{r, rd, wen && !ovf});
    end
    if (acc && as) begin
      m_n = r[15]; m_z = (r == 16'h0); m_o = o;
    end
    if (m_pend && ack) m_pend = 1'b0;
    else if (ovf) m_pend = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic mr, input logic fl, input logic ack);
    step(1'b0, ALU_AND, 16'h0, 1'b0, 4'h0, 1'b0, mr, fl, ack);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex_valid = 0; alu_r = 0; alu_o = 0; ex_crtl = 0; ex_rd = 0;
    ex_wen = 0; flush = 0; mem_ready = 1; exc_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {mem_valid, mem_r, mem_rd, mem_wen, flag_n, flag_z, flag_o, exc_req}, 0);
    rst_n = 1'b1;
    model_clear();
    #1;
    chk("rst_ready", ex_ready, 1);
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  c;
    logic [15:0] r;
    logic        mr;
    logic        fl;
    logic        e_mv;
    logic [15:0] e_r;
    logic        e_rdy;
    logic [2:0]  e_nzo;
  } vec_t;
  vec_t tbl[15];

  logic [3:0] codes[8];

  initial begin
    tbl[0]  = '{1'b1, ALU_SUB, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 3'b010};
    tbl[1]  = '{1'b1, ALU_AND, 16'h00F0, 1'b1, 1'b0, 1'b1, 16'h00F0, 1'b1, 3'b010};
    tbl[2]  = '{1'b0, ALU_AND, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'b010};
    tbl[3]  = '{1'b1, ALU_ADD, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 3'b000};
    tbl[4]  = '{1'b1, ALU_ADD, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 3'b000};
    tbl[5]  = '{1'b1, ALU_ADD, 16'h8003, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 3'b000};
    tbl[6]  = '{1'b1, ALU_ADD, 16'h8003, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 3'b000};
    tbl[7]  = '{1'b1, ALU_ADD, 16'h8003, 1'b1, 1'b0, 1'b1, 16'h8003, 1'b1, 3'b100};
    tbl[8]  = '{1'b0, ALU_AND, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'b100};
    tbl[9]  = '{1'b1, ALU_ADD, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 3'b000};
    tbl[10] = '{1'b1, ALU_ADD, 16'h0006, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 3'b000};
    tbl[11] = '{1'b1, ALU_SUB, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 3'b000};
    tbl[12] = '{1'b1, ALU_ADD, 16'h0007, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b1, 3'b000};
    tbl[13] = '{1'b1, ALU_SUB, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 3'b000};
    tbl[14] = '{1'b0, ALU_AND, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'b000};
    codes = '{ALU_ADD, ALU_SUB, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL, ALU_SLL};

    // Directed table: forwarding, skid fill/drain order, flush
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].c, tbl[i].r, 1'b0, i[3:0], 1'b1, tbl[i].mr, tbl[i].fl, 1'b0);
      chk($sformatf("tbl%0d_valid", i), mem_valid, tbl[i].e_mv);
      if (tbl[i].e_mv) chk($sformatf("tbl%0d_r", i), mem_r, tbl[i].e_r);
      chk($sformatf("tbl%0d_ready", i), ex_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_nzo", i), {flag_n, flag_z, flag_o}, tbl[i].e_nzo);
    end

    // Overflow add, exception hold, ack, ack in IDLE, ack together with flush
    do_reset();
    step(1'b1, ALU_ADD, 16'h8000, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ovf_r", mem_r, 16'h8000);
    chk("ovf_wen", mem_wen, !EXC_EN);
    chk("ovf_nzo", {flag_n, flag_z, flag_o}, 3'b101);
    chk("ovf_exc", exc_req, EXC_EN);
    chk("ovf_ready", ex_ready, !EXC_EN);
    idle(1'b0, 1'b0, 1'b0);
    chk("hold_exc", exc_req, EXC_EN);
    chk("hold_ready", ex_ready, !EXC_EN);
    idle(1'b1, 1'b0, 1'b1);
    chk("ack_exc", exc_req, 0);
    chk("ack_ready", ex_ready, 1);
    idle(1'b1, 1'b0, 1'b1);
    chk("idle_ack_exc", exc_req, 0);
    chk("idle_ack_ready", ex_ready, 1);
    step(1'b1, ALU_SUB, 16'h8001, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf2_exc", exc_req, EXC_EN);
    idle(1'b0, 1'b1, 1'b1);
    chk("flack_valid", mem_valid, 0);
    chk("flack_exc", exc_req, 0);
    chk("flack_ready", ex_ready, 1);

    // Asynchronous reset mid-stream with both entries valid
    do_reset();
    step(1'b1, ALU_ADD, 16'h0001, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, ALU_ADD, 16'h8000, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_ready", ex_ready, 0);
    chk("full_exc", exc_req, EXC_EN);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {mem_valid, mem_r, mem_rd, mem_wen, flag_n, flag_z, flag_o, exc_req}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    #1;
    chk("async_rel_ready", ex_ready, 1);
    idle(1'b1, 1'b0, 1'b0);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 7) == 0) r = 16'h0000;
      else if ($urandom_range(0, 7) == 0) r = 16'h8000;
      step($urandom_range(0, 3) != 0, codes[$urandom_range(0, 7)], r,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
